// File: rtl/addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_SUB = 1'b1;

endpackage

// File: rtl/addsub_bit_cell.sv
// Combinational 1-bit full add/sub cell; b is inverted internally when subtracting.
module addsub_bit_cell
  import addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic sel,
  output logic sum,
  output logic cout
);

  logic b_eff;

  assign b_eff = (sel == SEL_ADD) ? b : ~b;
  assign sum   = a ^ b_eff ^ cin;
  assign cout  = (a & b_eff) | (cin & (a ^ b_eff));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cell_sum, cell_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  addsub_bit_cell u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sel  (sel_q),
    .sum  (cell_sum),
    .cout (cell_cout)
  );

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          sel_d   = sel;
          // Subtract is a + ~b + 1: the +1 enters through the carry preset.
          carry_d = (sel == SEL_SUB);
          cnt_d   = '0;
          state_d = SHIFT;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        result_d = {cell_sum, result_q[WIDTH-1:1]};
        carry_d  = cell_cout;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          cout_d  = cell_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
          // carry_q here is the carry into the MSB position.
          ovf_d   = carry_q ^ cell_cout;
`endif
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub (WIDTH=8); checks ovf when SERIAL_ADDSUB_OVF_EN is defined.
module tb_serial_addsub;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf;
`endif

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sel    (sel),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             co;
    logic             ov;
    int               due;
    string            name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pop one expectation per done pulse; flag overdue expectations
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1, required no done (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_result"}, 64'(result), 64'(mon_e.res));
        check({mon_e.name, "_cout"}, 64'(cout), 64'(mon_e.co));
        check({mon_e.name, "_latency"}, 64'(cyc), 64'(mon_e.due));
`ifdef SERIAL_ADDSUB_OVF_EN
        check({mon_e.name, "_ovf"}, 64'(ovf), 64'(mon_e.ov));
`endif
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      mon_e = sb.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no done by cycle %0d, required done at %0d", mon_e.name, cyc, mon_e.due);
    end
  end

  task automatic push_exp(input logic [WIDTH-1:0] er, input logic ec, input logic eo,
                          input int due, input string nm);
    exp_t e;
    e.res  = er;
    e.co   = ec;
    e.ov   = eo;
    e.due  = due;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle start pulse; done expected 9 cycles after the drive cycle
  task automatic issue(input logic s, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                       input logic [WIDTH-1:0] er, input logic ec, input logic eo, input string nm);
    @(negedge clk);
    start = 1'b1;
    sel   = s;
    a     = aa;
    b     = bb;
    push_exp(er, ec, eo, cyc + 9, nm);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int c0;
    rst   = 1'b1;
    start = 1'b0;
    sel   = 1'b0;
    a     = '0;
    b     = '0;
    idle(3);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_result", 64'(result), 64'(0));
    check("reset_cout", 64'(cout), 64'(0));
    rst = 1'b0;
    idle(2);

    issue(1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1, "add_5a_3c");
    idle(10);
    issue(1'b1, 8'h5A, 8'h3C, 8'h1E, 1'b1, 1'b0, "sub_5a_3c");
    idle(10);
    issue(1'b1, 8'h3C, 8'h5A, 8'hE2, 1'b0, 1'b0, "sub_3c_5a");
    idle(10);
    issue(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, "add_ff_01");
    idle(10);
    issue(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, "add_7f_01");
    idle(10);

    // Start while busy is ignored; operand changes after acceptance have no effect
    @(negedge clk);
    start = 1'b1; sel = 1'b0; a = 8'h10; b = 8'h20;
    push_exp(8'h30, 1'b0, 1'b0, cyc + 9, "ignore_busy_start");
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1; a = 8'hFF; b = 8'hFF;
    check("busy_mid_shift", 64'(busy), 64'(1));
    @(negedge clk); start = 1'b0; a = 8'hAA; b = 8'h55; sel = 1'b1;
    idle(12);

    // Synchronous reset mid-operation aborts without a done pulse
    @(negedge clk);
    start = 1'b1; sel = 1'b0; a = 8'h5A; b = 8'h3C;
    @(negedge clk); start = 1'b0;
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_result", 64'(result), 64'(0));
    check("abort_cout", 64'(cout), 64'(0));
    idle(12);
    issue(1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, "after_abort_add");
    idle(10);

    // start held high: re-accepted every 10 cycles
    @(negedge clk);
    start = 1'b1; sel = 1'b0; a = 8'h11; b = 8'h22;
    c0 = cyc;
    push_exp(8'h33, 1'b0, 1'b0, c0 + 9,  "b2b_0");
    push_exp(8'h33, 1'b0, 1'b0, c0 + 19, "b2b_1");
    push_exp(8'h33, 1'b0, 1'b0, c0 + 29, "b2b_2");
    idle(25);
    start = 1'b0;
    idle(15);

    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL leftover_expectations: got %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
